fetch_ctrl: RTL

- Sequencer for the fetch stage.
- Issues instruction-memory requests, waits for a variable-latency ack, and pulses o_req_instr so the fetch stage latches the instruction and advances its PC.
- Holds instructions while decode is stalled, cancels in-flight fetches on branch redirect, and flags memory timeouts.
- Sits between the fetch PC register, instruction memory and decode.

---
 rtl/core_pkg.sv | 17 +
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the fetch stage: data width, reset instruction and
// the fetch sequencer state encoding.
package core_pkg;

    localparam int XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0); a harmless value for an empty buffer.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack bus between the fetch sequencer (master)
// and instruction memory (slave).
interface fetch_ctrl_if #(
    parameter int XLEN = core_pkg::XLEN
) ();

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: issues instruction-memory requests, hands returned
// instructions to fetch, holds them across decode stalls and handles redirects.
module fetch_ctrl #(
    parameter int XLEN    = core_pkg::XLEN,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    output logic            o_req_instr,
    output logic [XLEN-1:0] o_instr_data,
    fetch_ctrl_if.master    mem,
    output logic            o_dec_valid,
    input  logic            i_dec_ready,
    output logic            o_fetch_err
);

    import core_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            drop_q, drop_d;
    logic            dec_valid_q, dec_valid_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            slot_free;
    logic            timeout_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic            req_instr;
    logic            mem_req;
    logic [XLEN-1:0] instr_data;

    assign slot_free   = !dec_valid_q || i_dec_ready;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    // Fires on the TIMEOUT-th consecutive REQ cycle without an ack.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= FETCH_IDLE;
            mem_addr_q  <= '0;
            redir_q     <= '0;
            buf_q       <= XLEN'(INSTR_NOP);
            drop_q      <= 1'b0;
            dec_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            redir_q     <= redir_d;
            buf_q       <= buf_d;
            drop_q      <= drop_d;
            dec_valid_q <= dec_valid_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        redir_d    = redir_q;
        buf_d      = buf_q;
        drop_d     = drop_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        req_instr  = 1'b0;
        mem_req    = 1'b0;
        instr_data = mem.mem_rdata;

        case (state_q)
            FETCH_IDLE: begin
                state_d    = FETCH_REQ;
                mem_addr_d = i_branch_taken ? i_branch_target : i_pc;
                cnt_d      = '0;
            end

            FETCH_REQ: begin
                mem_req = 1'b1;
                if (mem.mem_ack) begin
                    cnt_d = '0;
                    if (drop_q) begin
                        // Stale response to a cancelled fetch: re-issue at the redirect.
                        drop_d     = 1'b0;
                        mem_addr_d = i_branch_taken ? i_branch_target : redir_q;
                    end else if (i_branch_taken) begin
                        mem_addr_d = i_branch_target;
                    end else if (slot_free) begin
                        req_instr  = 1'b1;
                        mem_addr_d = mem_addr_q + XLEN'(4);
                    end else begin
                        buf_d   = mem.mem_rdata;
                        state_d = FETCH_HOLD;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    drop_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = FETCH_ERR;
                end else begin
                    cnt_d = cnt_inc;
                    if (i_branch_taken) begin
                        // Address must stay stable until the outstanding ack arrives.
                        drop_d  = 1'b1;
                        redir_d = i_branch_target;
                    end
                end
            end

            FETCH_HOLD: begin
                instr_data = buf_q;
                cnt_d      = '0;
                if (i_branch_taken) begin
                    mem_addr_d = i_branch_target;
                    state_d    = FETCH_REQ;
                end else if (slot_free) begin
                    req_instr  = 1'b1;
                    mem_addr_d = i_pc + XLEN'(4);
                    state_d    = FETCH_REQ;
                end
            end

            FETCH_ERR: begin
                cnt_d = '0;
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_comb begin
        dec_valid_d = dec_valid_q;
        if (i_branch_taken) begin
            dec_valid_d = 1'b0;
        end else if (req_instr) begin
            dec_valid_d = 1'b1;
        end else if (dec_valid_q && i_dec_ready) begin
            dec_valid_d = 1'b0;
        end
    end

    assign o_req_instr  = req_instr;
    assign o_instr_data = instr_data;
    assign o_dec_valid  = dec_valid_q;
    assign o_fetch_err  = err_q;
    assign mem.mem_req  = mem_req;
    assign mem.mem_addr = mem_addr_q;

endmodule
